// File: rtl/lutram_stream_buf.sv
// Load-then-burst word buffer in distributed RAM; bursts emit LANES words per beat with address wrap.
// Optional macro LUTRAM_PARITY_EN adds one even-parity bit per stored word and drives perr/err.
module lutram_stream_buf #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 784,
    parameter int LANES      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [BIT_DEPTH-1:0]         wr_data,
    output logic                         wr_ready,
    output logic                         full,
    input  logic                         rd_start,
    input  logic [ADDR_WIDTH-1:0]        rd_base,
    input  logic [ADDR_WIDTH-1:0]        rd_len,
    output logic                         rd_busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*BIT_DEPTH-1:0]   out_data,
    output logic                         out_last,
    output logic                         done,
    output logic                         err,
    output logic                         perr
);
    localparam int CW = ADDR_WIDTH + $clog2(LANES) + 1;
    localparam int PW = ADDR_WIDTH + 1;
`ifdef LUTRAM_PARITY_EN
    localparam int MW = BIT_DEPTH + 1;
`else
    localparam int MW = BIT_DEPTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [MW-1:0]              r_mem [DEPTH];
    logic [PW-1:0]              r_wr_ptr;
    logic [ADDR_WIDTH-1:0]      r_base, r_len, r_beat;
    logic                       r_out_valid, r_out_last, r_err;
    logic [LANES*BIT_DEPTH-1:0] r_out_data;

    logic                       w_idle, w_wr_fire, w_rd_bad, w_rd_empty, w_rd_go;
    logic                       w_accept, w_load;
    logic [ADDR_WIDTH-1:0]      w_base, w_len, w_idx, w_addr;
    logic [CW-1:0]              w_sum;
    logic [MW-1:0]              w_word;
    logic [LANES*BIT_DEPTH-1:0] w_beat_data;
    logic                       w_beat_last, w_beat_perr;

    assign w_idle     = (r_state == S_IDLE);
    assign wr_ready   = w_idle && (r_wr_ptr < PW'(DEPTH));
    assign full       = (r_wr_ptr == PW'(DEPTH));
    assign w_wr_fire  = rst_n && !clear && wr_valid && wr_ready;
    assign w_rd_bad   = ({1'b0, rd_base} >= PW'(DEPTH));
    assign w_rd_empty = (rd_len == '0);
    assign w_rd_go    = w_idle && rd_start && !w_rd_bad && !w_rd_empty;
    assign w_accept   = r_out_valid && out_ready;
    // Next beat is fetched on the same edge the current one is taken, so valid never bubbles.
    assign w_load     = w_rd_go || (w_accept && !r_out_last);

    assign rd_busy   = !w_idle;
    assign done      = (r_state == S_DONE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
`ifdef LUTRAM_PARITY_EN
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {^wr_data, wr_data};
`else
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
        end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Gather the beat at (base + idx*LANES + k) mod DEPTH, widened so the sum never truncates.
    always_comb begin
        w_base      = w_idle ? rd_base : r_base;
        w_len       = w_idle ? rd_len : r_len;
        w_idx       = w_idle ? '0 : r_beat + 1'b1;
        w_sum       = '0;
        w_addr      = '0;
        w_word      = '0;
        w_beat_data = '0;
        w_beat_perr = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_sum  = CW'(w_base) + CW'(w_idx) * CW'(LANES) + CW'(k);
            w_addr = ADDR_WIDTH'(w_sum % CW'(DEPTH));
            w_word = r_mem[w_addr];
            w_beat_data[k*BIT_DEPTH +: BIT_DEPTH] = w_word[BIT_DEPTH-1:0];
`ifdef LUTRAM_PARITY_EN
            if (^w_word) w_beat_perr = 1'b1;
`endif
        end
        w_beat_last = (w_idx == w_len - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rd_start) w_state_nxt = (w_rd_bad || w_rd_empty) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (w_accept && r_out_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef LUTRAM_PARITY_EN
    logic r_perr;
    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
`ifdef LUTRAM_PARITY_EN
            r_perr      <= 1'b0;
`endif
        end else begin
            if (clear) begin
                r_err <= 1'b0;
            end else if ((w_idle && rd_start && w_rd_bad) || (w_load && w_beat_perr)) begin
                r_err <= 1'b1;
            end

            if (w_rd_go) begin
                r_base <= rd_base;
                r_len  <= rd_len;
                r_beat <= '0;
            end else if (w_load) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat_data;
                r_out_last  <= w_beat_last;
`ifdef LUTRAM_PARITY_EN
                r_perr      <= w_beat_perr;
`endif
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
`ifdef LUTRAM_PARITY_EN
                r_perr      <= 1'b0;
`endif
            end
        end
    end

endmodule
